// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync, visible strobe and line/frame pulses.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
  localparam logic [10:0] H_VIS_W = 11'(H_VIS);
  localparam logic [10:0] V_VIS_W = 11'(V_VIS);
  localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       hs_act;
  logic       vs_act;
  logic       vis_next;
  logic       frame_wrap;

  // Decode everything from the next count so registered strobes line up with DrawX/DrawY.
  always_comb begin
    h_wrap     = (DrawX == H_LAST);
    v_wrap     = (DrawY == V_LAST);
    x_next     = h_wrap ? 10'd0 : DrawX + 10'd1;
    y_next     = DrawY;
    if (h_wrap) begin
      y_next = v_wrap ? 10'd0 : DrawY + 10'd1;
    end
    frame_wrap = h_wrap && v_wrap;
    hs_act     = ({1'b0, x_next} >= HS_BEG) && ({1'b0, x_next} < HS_END);
    vs_act     = ({1'b0, y_next} >= VS_BEG) && ({1'b0, y_next} < VS_END);
    vis_next   = ({1'b0, x_next} < H_VIS_W) && ({1'b0, y_next} < V_VIS_W);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= x_next;
      DrawY       <= y_next;
      hs          <= hs_act ? HS_POL : ~HS_POL;
      vs          <= vs_act ? VS_POL : ~VS_POL;
      blank       <= vis_next;
      line_start  <= h_wrap;
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_count_reg;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_count_reg <= 8'd0;
    end else if (frame_wrap) begin
      frame_count_reg <= frame_count_reg + 8'd1;
    end
  end

  assign frame_count = frame_count_reg;
`else
  assign frame_count = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line behaviour, tiny-timing instance for frame behaviour.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int FC1 = 1;
  localparam int FC2 = 2;
`else
  localparam int FC1 = 0;
  localparam int FC2 = 0;
`endif

  logic       clk;
  logic       rst_d;
  logic       rst_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic       hs_d, vs_d, bl_d, ls_d, fs_d;
  logic       hs_s, vs_s, bl_s, ls_s, fs_s;
  logic [7:0] fc_d, fc_s;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen dut_d (
    .vga_clk(clk), .reset(rst_d), .DrawX(x_d), .DrawY(y_d), .hs(hs_d), .vs(vs_d),
    .blank(bl_d), .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_VIS(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_s (
    .vga_clk(clk), .reset(rst_s), .DrawX(x_s), .DrawY(y_s), .hs(hs_s), .vs(vs_s),
    .blank(bl_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int hs_low, ls_cnt, ls_idx;
  int fs_cnt, hs_high, hs_bad, vs_low;

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;

    // Default timing: reset values, then the first line
    tick(3);
    check_eq("rst_x",   x_d,  0);
    check_eq("rst_y",   y_d,  0);
    check_eq("rst_hs",  hs_d, 1);
    check_eq("rst_vs",  vs_d, 1);
    check_eq("rst_bl",  bl_d, 0);
    check_eq("rst_ls",  ls_d, 0);
    check_eq("rst_fs",  fs_d, 0);
    check_eq("rst_fc",  fc_d, 0);

    rst_d = 1'b0;
    tick(1);
    check_eq("first_x",  x_d,  1);
    check_eq("first_y",  y_d,  0);
    check_eq("first_bl", bl_d, 1);
    check_eq("first_ls", ls_d, 0);
    check_eq("first_fs", fs_d, 0);

    tick(638); check_eq("bl_639", bl_d, 1);
    tick(1);   check_eq("x_640", x_d, 640); check_eq("bl_640", bl_d, 0);
    tick(15);  check_eq("hs_655", hs_d, 1);
    tick(1);   check_eq("hs_656", hs_d, 0);
    tick(95);  check_eq("hs_751", hs_d, 0);
    tick(1);   check_eq("hs_752", hs_d, 1);
    tick(47);  check_eq("x_799", x_d, 799); check_eq("ls_799", ls_d, 0);
    tick(1);
    check_eq("wrap_x",  x_d,  0);
    check_eq("wrap_y",  y_d,  1);
    check_eq("wrap_ls", ls_d, 1);
    check_eq("wrap_fs", fs_d, 0);
    check_eq("wrap_bl", bl_d, 1);

    hs_low = 0; ls_cnt = 0; ls_idx = -1;
    for (int i = 0; i < 800; i++) begin
      tick(1);
      if (!hs_d) hs_low++;
      if (ls_d) begin
        ls_cnt++;
        ls_idx = i;
      end
    end
    check_eq("line_hs_low", hs_low, 96);
    check_eq("line_ls_cnt", ls_cnt, 1);
    check_eq("line_ls_per", ls_idx, 799);
    check_eq("line2_y",     y_d,    2);

    tick(700);
    check_eq("mid_x", x_d, 700);
    rst_d = 1'b1;
    tick(1);
    check_eq("midrst_x",  x_d,  0);
    check_eq("midrst_y",  y_d,  0);
    check_eq("midrst_fs", fs_d, 0);
    check_eq("midrst_bl", bl_d, 0);
    check_eq("midrst_fc", fc_d, 0);
    rst_d = 1'b0;

    // Tiny timing: 7-cycle line, 42-cycle frame, hs active-high at x=5
    check_eq("s_rst_hs", hs_s, 0);
    check_eq("s_rst_vs", vs_s, 1);
    check_eq("s_rst_bl", bl_s, 0);
    rst_s = 1'b0;
    tick(1);
    check_eq("s_first_x",  x_s,  1);
    check_eq("s_first_bl", bl_s, 1);
    check_eq("s_first_fs", fs_s, 0);
    tick(40);
    check_eq("s_corner_x",  x_s,  6);
    check_eq("s_corner_y",  y_s,  5);
    check_eq("s_corner_bl", bl_s, 0);
    check_eq("s_corner_fs", fs_s, 0);
    tick(1);
    check_eq("s_wrap_x",  x_s,  0);
    check_eq("s_wrap_y",  y_s,  0);
    check_eq("s_wrap_fs", fs_s, 1);
    check_eq("s_wrap_ls", ls_s, 1);
    check_eq("s_wrap_bl", bl_s, 1);
    check_eq("s_fc1",     fc_s, FC1);

    fs_cnt = 0; ls_cnt = 0; hs_high = 0; hs_bad = 0; vs_low = 0;
    for (int i = 0; i < 42; i++) begin
      tick(1);
      if (fs_s) fs_cnt++;
      if (ls_s) ls_cnt++;
      if (hs_s) hs_high++;
      if (hs_s != (x_s == 10'd5)) hs_bad++;
      if (!vs_s) vs_low++;
    end
    check_eq("s_fs_cnt",  fs_cnt,  1);
    check_eq("s_ls_cnt",  ls_cnt,  6);
    check_eq("s_hs_high", hs_high, 6);
    check_eq("s_hs_pos",  hs_bad,  0);
    check_eq("s_vs_low",  vs_low,  7);
    check_eq("s_end_fs",  fs_s,    1);
    check_eq("s_fc2",     fc_s,    FC2);

    tick(10);
    check_eq("s_mid_x", x_s, 3);
    check_eq("s_mid_y", y_s, 1);
    rst_s = 1'b1;
    tick(1);
    check_eq("s_midrst_x",  x_s,  0);
    check_eq("s_midrst_y",  y_s,  0);
    check_eq("s_midrst_fs", fs_s, 0);
    check_eq("s_midrst_fc", fc_s, 0);
    rst_s = 1'b0;
    tick(1);
    check_eq("s_rel_x",  x_s,  1);
    check_eq("s_rel_fs", fs_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
